// File: rtl/mem_chunk_pkg.sv
// rtl/mem_chunk_pkg.sv - shared constants, slot-state enum and index-width helper
// Purpose : common definitions for the memory-path chunk serializer.
// Contents: WORD_W_DEF / CHUNK_W_DEF defaults, slot_t occupancy enum,
//           idx_width() = clog2 with a floor of 1 bit.
package mem_chunk_pkg;

  localparam int WORD_W_DEF  = 480;
  localparam int CHUNK_W_DEF = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  // Bits needed to index n chunks; never less than 1 so ports stay legal.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/chunk_select.sv
// rtl/chunk_select.sv - combinational chunk mux for the serializer
// Purpose : pick chunk number idx out of a storage word.
// Ports   : word  in  WORD_W  storage word
//           idx   in  IDX_W   chunk index in emission order
//           chunk out CHUNK_W selected chunk
module chunk_select
  import mem_chunk_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int CHUNK_W    = CHUNK_W_DEF,
  parameter int LSB_FIRST  = 1,
  localparam int NUM_CHUNKS = WORD_W / CHUNK_W,
  localparam int IDX_W      = idx_width(NUM_CHUNKS)
) (
  input  logic [WORD_W-1:0]  word,
  input  logic [IDX_W-1:0]   idx,
  output logic [CHUNK_W-1:0] chunk
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  // Table padded to a power of two so every idx value selects a defined entry.
  logic [CHUNK_W-1:0] slots [2**IDX_W];
  logic [IDX_W-1:0]   pos;

  for (genvar k = 0; k < 2**IDX_W; k++) begin : g_slot
    if (k < NUM_CHUNKS) begin : g_used
      assign slots[k] = word[k*CHUNK_W +: CHUNK_W];
    end else begin : g_pad
      assign slots[k] = '0;
    end
  end

  // MSB-first order walks the table from the top chunk down.
  assign pos   = (LSB_FIRST != 0) ? idx : (LAST_IDX - idx);
  assign chunk = slots[pos];

endmodule

// File: rtl/mem_chunk_serializer.sv
// rtl/mem_chunk_serializer.sv - wide-word to narrow-chunk serializer with one-word hold
// Purpose : accept WORD_W-bit words on a valid/ready handshake and emit them as
//           NUM_CHUNKS chunks of CHUNK_W bits for the frame/line memory writer.
// Ports   : clk, rst (sync active-high), abort (sync discard)
//           in_valid/in_ready/in_data     word input handshake
//           out_valid/out_ready/out_data  chunk output handshake
//           out_idx, out_last             chunk position within its word
//           wr_en                         out_valid & out_ready
//           words_done                    completed-word counter (wraps)
module mem_chunk_serializer
  import mem_chunk_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int CHUNK_W    = CHUNK_W_DEF,
  parameter int LSB_FIRST  = 1,
  parameter int CNT_W      = 16,
  localparam int NUM_CHUNKS = WORD_W / CHUNK_W,
  localparam int IDX_W      = idx_width(NUM_CHUNKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHUNK_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               wr_en,
  output logic [CNT_W-1:0]   words_done
);

  if ((WORD_W % CHUNK_W) != 0 || (WORD_W / CHUNK_W) < 2) begin : g_bad_geometry
    $error("mem_chunk_serializer: WORD_W must be a multiple of CHUNK_W with at least 2 chunks");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  slot_t              active_st;
  slot_t              hold_st;
  logic [WORD_W-1:0]  active_word;
  logic [WORD_W-1:0]  hold_word;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   done_q;

  logic accept;
  logic last_xfer;
  logic load_active;
  logic load_hold;

  // Both status outputs come straight from slot flops, so they are registered.
  assign out_valid  = (active_st == SLOT_FULL);
  assign in_ready   = (hold_st == SLOT_EMPTY);
  assign out_idx    = idx_q;
  assign out_last   = out_valid & (idx_q == LAST_IDX);
  assign wr_en      = out_valid & out_ready;
  assign words_done = done_q;

  assign accept    = in_valid & in_ready;
  assign last_xfer = wr_en & (idx_q == LAST_IDX);

  // A new word goes straight to ACTIVE when ACTIVE is free now or is being
  // vacated this cycle with nothing waiting in HOLD; otherwise it parks in HOLD.
  assign load_active = accept & ((active_st == SLOT_EMPTY) |
                                 (last_xfer & (hold_st == SLOT_EMPTY)));
  assign load_hold   = accept & ~load_active;

  chunk_select #(
    .WORD_W    (WORD_W),
    .CHUNK_W   (CHUNK_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_chunk_select (
    .word  (active_word),
    .idx   (idx_q),
    .chunk (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      active_st <= SLOT_EMPTY;
      hold_st   <= SLOT_EMPTY;
      idx_q     <= '0;
      done_q    <= '0;
    end else if (abort) begin
      // Discard everything; a last chunk leaving in this cycle is not counted
      // and any word offered in this cycle is ignored.
      active_st <= SLOT_EMPTY;
      hold_st   <= SLOT_EMPTY;
      idx_q     <= '0;
    end else begin
      if (last_xfer) begin
        idx_q  <= '0;
        done_q <= done_q + CNT_W'(1);
        if (hold_st == SLOT_FULL) begin
          active_word <= hold_word;
          hold_st     <= SLOT_EMPTY;
        end else if (!accept) begin
          active_st <= SLOT_EMPTY;
        end
      end else if (wr_en) begin
        idx_q <= idx_q + IDX_W'(1);
      end

      if (load_active) begin
        active_word <= in_data;
        active_st   <= SLOT_FULL;
      end

      if (load_hold) begin
        hold_word <= in_data;
        hold_st   <= SLOT_FULL;
      end
    end
  end

endmodule

// File: tb/tb_mem_chunk_serializer.sv
// tb/tb_mem_chunk_serializer.sv - scoreboard bench for mem_chunk_serializer
module tb_mem_chunk_serializer;
  import mem_chunk_pkg::*;

  localparam int WW = 480;
  localparam int CW = 16;
  localparam int NC = WW / CW;
  localparam int IW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [WW-1:0] in_data = '0;

  logic          a_in_ready, a_out_valid, a_out_last, a_wr_en;
  logic [CW-1:0] a_out_data;
  logic [IW-1:0] a_out_idx;
  logic [15:0]   a_words_done;
  logic          b_in_ready, b_out_valid, b_out_last, b_wr_en;
  logic [CW-1:0] b_out_data;
  logic [IW-1:0] b_out_idx;
  logic [15:0]   b_words_done;

  mem_chunk_serializer #(.WORD_W(WW), .CHUNK_W(CW), .LSB_FIRST(1), .CNT_W(16)) dut_lsb (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_idx(a_out_idx), .out_last(a_out_last), .wr_en(a_wr_en), .words_done(a_words_done)
  );

  mem_chunk_serializer #(.WORD_W(WW), .CHUNK_W(CW), .LSB_FIRST(0), .CNT_W(16)) dut_msb (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_idx(b_out_idx), .out_last(b_out_last), .wr_en(b_wr_en), .words_done(b_words_done)
  );

  typedef struct {
    logic [CW-1:0] dl;
    logic [CW-1:0] dm;
    int            idx;
    bit            last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_done = 0;
  bit   chk_en = 1'b0;
  int   ready_mode = 0;
  bit   stall = 1'b0;
  logic [CW-1:0] stall_d;
  logic [IW-1:0] stall_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue side: an accepted word expands into its NC expected chunks.
  always @(negedge clk) begin
    if (chk_en && !rst && !abort && in_valid && a_in_ready) begin
      for (int k = 0; k < NC; k++) begin
        exp_t e;
        e.dl   = in_data[k*CW +: CW];
        e.dm   = in_data[(NC-1-k)*CW +: CW];
        e.idx  = k;
        e.last = (k == NC-1);
        q.push_back(e);
      end
    end
  end

  // Transfer side: retire chunks on each handshake, track stalls and completions.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_en", 32'(a_wr_en), 32'(a_out_valid & out_ready));
      if (rst) begin
        q.delete();
        exp_done = 0;
        stall = 1'b0;
      end else begin
        if (stall && a_out_valid) begin
          chk("stall_data", 32'(a_out_data), 32'(stall_d));
          chk("stall_idx", 32'(a_out_idx), 32'(stall_i));
        end
        stall   = a_out_valid && !out_ready && !abort;
        stall_d = a_out_data;
        stall_i = a_out_idx;
        if (a_wr_en) begin
          if (q.size() == 0) begin
            fail_now("pop_on_empty_model");
          end else begin
            exp_t e;
            e = q.pop_front();
            if (e.last && !abort) exp_done++;
          end
        end
        if (abort) q.delete();
      end
    end
  end

  // Output state vs model, sampled just after the active edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      int flight;
      flight = (q.size() + NC - 1) / NC;
      chk("out_valid", 32'(a_out_valid), 32'(q.size() != 0));
      chk("msb_out_valid", 32'(b_out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(a_in_ready), 32'(flight < 2));
      chk("words_done", 32'(a_words_done), 32'(exp_done[15:0]));
      chk("msb_words_done", 32'(b_words_done), 32'(exp_done[15:0]));
      if (q.size() != 0) begin
        chk("out_data", 32'(a_out_data), 32'(q[0].dl));
        chk("msb_out_data", 32'(b_out_data), 32'(q[0].dm));
        chk("out_idx", 32'(a_out_idx), 32'(q[0].idx));
        chk("out_last", 32'(a_out_last), 32'(q[0].last));
        chk("msb_out_last", 32'(b_out_last), 32'(q[0].last));
      end else begin
        chk("idle_out_idx", 32'(a_out_idx), 32'(0));
        chk("idle_out_last", 32'(a_out_last), 32'(0));
      end
    end
  end

  // Downstream readiness pattern.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [WW-1:0] ramp_word();
    logic [WW-1:0] w;
    for (int k = 0; k < NC; k++) w[k*CW +: CW] = CW'(k);
    return w;
  endfunction

  task automatic send_word(input logic [WW-1:0] w);
    int guard;
    in_valid = 1'b1;
    in_data  = w;
    guard    = 0;
    while (!a_in_ready && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) fail_now("send_word_timeout");
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 4000) begin
      tick();
      guard++;
    end
    if (guard >= 4000) fail_now("drain_timeout");
    tick();
  endtask

  task automatic wait_idx(input int target);
    int guard;
    guard = 0;
    while (!(a_out_valid && a_out_idx == IW'(target)) && guard < 2000) begin
      tick();
      guard++;
    end
    if (guard >= 2000) fail_now("wait_idx_timeout");
  endtask

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single ramp word, continuous drain.
    ready_mode = 0;
    send_word(ramp_word());
    wait_idle();

    // Back-to-back pair with in_valid held.
    send_word(rand_word());
    send_word(rand_word());
    wait_idle();

    // Alternating backpressure.
    ready_mode = 1;
    send_word(ramp_word());
    send_word(rand_word());
    wait_idle();

    // Abort mid-word with HOLD full; a word offered in the abort cycle is dropped.
    ready_mode = 0;
    send_word(rand_word());
    send_word(rand_word());
    wait_idx(10);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = rand_word();
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    tick();
    send_word(ramp_word());
    wait_idle();

    // Reset mid-word while a word is offered.
    send_word(rand_word());
    wait_idx(15);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = rand_word();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    // Randomized traffic with random backpressure, gaps and occasional aborts.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send_word(rand_word());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 40)) tick();
      end
      if ((i % 13) == 7) begin
        repeat ($urandom_range(0, 20)) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_chunk_serializer.md
Name: mem_chunk_serializer

Overview:
- Parametrised wide-word to narrow-chunk serializer for the VGA memory path.
- Accepts a WORD_W-bit storage word over a valid/ready handshake and emits it as WORD_W/CHUNK_W chunks of CHUNK_W bits.
- Each chunk comes with a write strobe, chunk index and last flag, for the frame/line memory writer.
- A one-word holding register lets the next word be loaded while the current one streams, so back-to-back words have no bubble.

Parameters:
- WORD_W, 480, width of input storage word in bits.
- CHUNK_W, 16, width of each output chunk in bits.
- LSB_FIRST, 1, 1 = chunk 0 is bits [CHUNK_W-1:0]; 0 = chunk 0 is the top CHUNK_W bits.
- CNT_W, 16, width of the completed-word counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- abort  in  1  synchronous discard of active and held words.
- in_valid  in  1  in_data is presented.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WORD_W  storage word.
- out_valid  out  1  out_data holds a valid chunk.
- out_ready  in  1  downstream accepts the chunk.
- out_data  out  CHUNK_W  current chunk.
- out_idx  out  IDX_W  chunk index 0..NUM_CHUNKS-1; IDX_W = clog2(NUM_CHUNKS).
- out_last  out  1  current chunk is the final one of its word.
- wr_en  out  1  write strobe = out_valid & out_ready (combinational).
- words_done  out  CNT_W  count of fully emitted words, wraps at 2^CNT_W.

Behaviour:
- NUM_CHUNKS = WORD_W/CHUNK_W.
- Elaboration error if WORD_W % CHUNK_W != 0 or NUM_CHUNKS < 2.
- One clock; reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_idx=0, out_last=0, words_done=0, active/hold empty.
- out_data is don't-care while out_valid=0; bench must not check it.
- rst has priority over every other input. Reset mid-word drops all data with no partial completion and no words_done increment.
- State: ACTIVE (empty/full, shift register, idx counter) plus HOLD (empty/full, word register).
- in_ready is registered and equals !hold_full; there is no same-cycle bypass when the last chunk leaves.
- Accept = in_valid & in_ready.
  - If ACTIVE is empty, or its last chunk is handshaking this cycle with HOLD empty, the word loads into ACTIVE.
  - Otherwise the word loads into HOLD.
- Latency: chunk 0 of an accepted word is presented with out_valid=1 on the cycle after acceptance, when ACTIVE was free.
- out_valid=1 whenever ACTIVE is full.
- out_data, out_idx and out_last are stable while out_valid & !out_ready.
- On wr_en:
  - Not last: idx increments by 1; data advances to the next chunk in LSB_FIRST order.
  - Last (idx = NUM_CHUNKS-1): idx wraps to 0 and words_done increments by 1.
  - Last with HOLD full: HOLD moves to ACTIVE, out_valid stays 1, and in_ready rises next cycle.
  - Last with HOLD empty and a same-cycle accept: the new word goes straight to ACTIVE, out_valid stays 1.
  - Last with neither: out_valid=0 next cycle.
- out_last = out_valid & (idx == NUM_CHUNKS-1).
- abort (no rst): next cycle ACTIVE and HOLD are empty, idx=0, in_ready=1, and words_done is unchanged.
  - An in_valid in the abort cycle is ignored.
  - wr_en in the abort cycle still counts as a transfer, but a last chunk completed by it does not increment words_done.
- Full condition: ACTIVE and HOLD both full gives in_ready=0; in_valid is held off with no data loss.
- Empty condition: out_valid=0; out_ready is ignored.

Decomposition:
- Package mem_chunk_pkg holds:
  - default constants WORD_W_DEF=480 and CHUNK_W_DEF=16;
  - an idx-width helper function (clog2);
  - the slot-state enum (SLOT_EMPTY, SLOT_FULL).
- One sub-module, chunk_select, is natural: a combinational mux taking word, idx and LSB_FIRST and producing the chunk.
  - The top level may alternatively shift ACTIVE and use chunk_select only for MSB/LSB ordering.

Test Plan:
- Reset, then one word 0x..._0003_0002_0001_0000 (chunk k = k), out_ready=1 -> 30 consecutive wr_en cycles, out_data 0..29, out_last only on idx 29, words_done=1.
- Back-to-back: in_valid held high with words A then B, out_ready=1 -> 60 continuous wr_en cycles with no gap; in_ready low while HOLD is full.
- Backpressure: toggle out_ready 1/0 on alternate cycles -> out_data/out_idx stable on stall cycles; order and count unchanged.
- LSB_FIRST=0 with the same word -> first out_data=29, last=0; out_last on the 30th transfer.
- abort asserted at idx=10 with HOLD full -> next cycle out_valid=0, in_ready=1, words_done unchanged; a new word restarts at idx 0.
- rst pulse at idx=15 with in_valid=1 -> no accept during rst; all outputs at reset values next cycle; words_done=0.
